// File: rtl/featuremap_pad_writer.sv
// Streams one zero-bordered (HEIGHT+2)x(WIDTH+2) feature-map frame into a downstream FIFO.
// Optional build macro PAD_WRITER_RELU_EN clamps negative data words to zero.
module featuremap_pad_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic                  fifo_full,
    output logic                  wrreq,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done
);

    localparam int RW = $clog2(HEIGHT + 2);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RW-1:0]   r_row;
    logic [RW-1:0]   w_row_nxt;
    logic [CW-1:0]   r_col;
    logic [CW-1:0]   w_col_nxt;
    logic            w_pad;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_pad = (r_row == '0) || (r_row == ROW_LAST) ||
                   (r_col == '0) || (r_col == COL_LAST);

`ifdef PAD_WRITER_RELU_EN
    assign w_word = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
    assign w_word = data_in;
`endif

    // Handshake outputs are forced low while rst is high, regardless of state.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        wrreq    = 1'b0;
        ready_in = 1'b0;
        data_out = '0;
        if (!rst) begin
            case (r_state)
                RUN: begin
                    busy = 1'b1;
                    if (w_pad) begin
                        wrreq = !fifo_full;
                    end else begin
                        ready_in = !fifo_full;
                        wrreq    = valid_in && !fifo_full;
                        data_out = w_word;
                    end
                end
                FIN:     done = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            RUN: begin
                if (wrreq) begin
                    if (r_col == COL_LAST) begin
                        w_col_nxt = '0;
                        if (r_row == ROW_LAST) begin
                            w_state_nxt = FIN;
                        end else begin
                            w_row_nxt = r_row + RW'(1);
                        end
                    end else begin
                        w_col_nxt = r_col + CW'(1);
                    end
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Directed bench for featuremap_pad_writer on a 4x3 map (6x5 padded frame).
// Expected ReLU behaviour follows PAD_WRITER_RELU_EN at compile time.
module tb_featuremap_pad_writer;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = W + 2;
    localparam int NW = (H + 2) * (W + 2);
    localparam int ND = H * W;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          ready_in;
    logic          fifo_full;
    logic          wrreq;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          done;

    int errs   = 0;
    int checks = 0;

    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          accepted;
    int          done_cyc;
    int          stall_bad;
    int          gap_bad;

    featuremap_pad_writer #(
        .DATA_WIDTH(DW),
        .WIDTH     (W),
        .HEIGHT    (H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .fifo_full(fifo_full),
        .wrreq    (wrreq),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fdata(input int mode, input int k);
        if (mode == 0) return 32'(k + 1);
        return (k % 2 == 1) ? 32'hBF800000 : 32'h3F800000;
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef PAD_WRITER_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] exp_word(input int i, input int mode);
        int r;
        int c;
        r = i / PW;
        c = i % PW;
        if (r == 0 || r == H + 1 || c == 0 || c == W + 1) return 32'h0;
        return relu(fdata(mode, (r - 1) * W + (c - 1)));
    endfunction

    // Runs one frame and records every write; performs no comparisons itself.
    task automatic drive_frame(input int mode, input int stall_at, input int stall_len,
                               input int gap_at, input int gap_len, input int abort_at,
                               input bit start_pulses);
        int  stall_rem;
        int  gap_rem;
        int  w;
        bit  stalling;
        bit  gapping;
        wr_data.delete();
        wr_cyc.delete();
        accepted  = 0;
        done_cyc  = -1;
        stall_bad = 0;
        gap_bad   = 0;
        stall_rem = stall_len;
        gap_rem   = gap_len;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            w = wr_data.size();
            if (abort_at >= 0 && w == abort_at) break;
            stalling = (w == stall_at) && (stall_rem > 0);
            if (stalling) stall_rem--;
            gapping = (w == gap_at) && (gap_rem > 0) && !stalling;
            if (gapping) gap_rem--;
            fifo_full = stalling;
            valid_in  = !gapping;
            data_in   = fdata(mode, accepted);
            start     = start_pulses && (c == 3 || c == 17);
            @(negedge clk);
            if (stalling && (wrreq || ready_in)) stall_bad++;
            if (gapping && wrreq) gap_bad++;
            if (wrreq) begin
                wr_data.push_back(data_out);
                wr_cyc.push_back(c);
            end
            if (valid_in && ready_in) accepted++;
            if (done) begin
                done_cyc = c;
                start    = start_pulses;
                @(posedge clk); #1;
                start = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        fifo_full = 1'b0;
        if (abort_at < 0) valid_in = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, wrreq, ready_in} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_outputs: got %b want 0000", {busy, done, wrreq, ready_in});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        valid_in = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, wrreq, ready_in} !== 4'b0000 || data_out !== 32'h0) begin
            errs++;
            $display("FAIL idle_outputs: got %b/%h want 0000/0", {busy, done, wrreq, ready_in}, data_out);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic test_basic_frame;
        drive_frame(0, -1, 0, -1, 0, -1, 1'b0);
        checks++;
        if (wr_data.size() !== NW) begin
            errs++;
            $display("FAIL basic_count: got %0d want %0d", wr_data.size(), NW);
        end
        for (int i = 0; i < wr_data.size() && i < NW; i++) begin
            checks++;
            if (wr_data[i] !== exp_word(i, 0)) begin
                errs++;
                $display("FAIL basic_word[%0d]: got %h want %h", i, wr_data[i], exp_word(i, 0));
            end
        end
        checks++;
        if (accepted !== ND) begin
            errs++;
            $display("FAIL basic_accepted: got %0d want %0d", accepted, ND);
        end
        checks++;
        if (done_cyc < 0 || done_cyc !== wr_cyc[wr_cyc.size() - 1] + 1) begin
            errs++;
            $display("FAIL basic_done_timing: got cycle %0d want %0d", done_cyc, wr_cyc[wr_cyc.size() - 1] + 1);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errs++;
            $display("FAIL basic_back_idle: got %b want 00", {busy, done});
        end
    endtask

    task automatic test_fifo_stall;
        drive_frame(0, 2 * PW + 3, 5, -1, 0, -1, 1'b0);
        checks++;
        if (stall_bad !== 0) begin
            errs++;
            $display("FAIL stall_quiet: got %0d active cycles want 0", stall_bad);
        end
        checks++;
        if (wr_data.size() !== NW) begin
            errs++;
            $display("FAIL stall_count: got %0d want %0d", wr_data.size(), NW);
        end
        for (int i = 0; i < wr_data.size() && i < NW; i++) begin
            checks++;
            if (wr_data[i] !== exp_word(i, 0)) begin
                errs++;
                $display("FAIL stall_word[%0d]: got %h want %h", i, wr_data[i], exp_word(i, 0));
            end
        end
        checks++;
        if (wr_data.size() == NW && wr_cyc[15] - wr_cyc[14] !== 6) begin
            errs++;
            $display("FAIL stall_gap_cycles: got %0d want 6", wr_cyc[15] - wr_cyc[14]);
        end
        checks++;
        if (done_cyc < 0) begin
            errs++;
            $display("FAIL stall_done: got no done want done");
        end
    endtask

    task automatic test_valid_gap;
        drive_frame(0, -1, 0, PW + 2, 3, -1, 1'b0);
        checks++;
        if (gap_bad !== 0) begin
            errs++;
            $display("FAIL gap_no_write: got %0d writes want 0", gap_bad);
        end
        checks++;
        if (wr_data.size() !== NW) begin
            errs++;
            $display("FAIL gap_count: got %0d want %0d", wr_data.size(), NW);
        end
        for (int i = 0; i < wr_data.size() && i < NW; i++) begin
            checks++;
            if (wr_data[i] !== exp_word(i, 0)) begin
                errs++;
                $display("FAIL gap_word[%0d]: got %h want %h", i, wr_data[i], exp_word(i, 0));
            end
        end
        checks++;
        if (wr_data.size() == NW && wr_cyc[8] - wr_cyc[7] !== 4) begin
            errs++;
            $display("FAIL gap_cycles: got %0d want 4", wr_cyc[8] - wr_cyc[7]);
        end
    endtask

    task automatic test_reset_midframe;
        drive_frame(0, -1, 0, -1, 0, 10, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, wrreq, ready_in} !== 4'b0000) begin
            errs++;
            $display("FAIL midrst_outputs: got %b want 0000", {busy, done, wrreq, ready_in});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, wrreq, ready_in} !== 3'b000) begin
                errs++;
                $display("FAIL midrst_idle[%0d]: got %b want 000", i, {busy, wrreq, ready_in});
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        drive_frame(0, -1, 0, -1, 0, -1, 1'b0);
        checks++;
        if (wr_data.size() !== NW || accepted !== ND) begin
            errs++;
            $display("FAIL midrst_fresh_count: got %0d/%0d want %0d/%0d", wr_data.size(), accepted, NW, ND);
        end
        for (int i = 0; i < wr_data.size() && i < NW; i++) begin
            checks++;
            if (wr_data[i] !== exp_word(i, 0)) begin
                errs++;
                $display("FAIL midrst_word[%0d]: got %h want %h", i, wr_data[i], exp_word(i, 0));
            end
        end
    endtask

    task automatic test_back_to_back;
        drive_frame(0, -1, 0, -1, 0, -1, 1'b1);
        checks++;
        if (wr_data.size() !== NW || done_cyc < 0) begin
            errs++;
            $display("FAIL b2b_first_count: got %0d done=%0d want %0d", wr_data.size(), done_cyc, NW);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL b2b_start_at_fin: got busy=%b want 0", busy);
        end
        drive_frame(0, -1, 0, -1, 0, -1, 1'b0);
        checks++;
        if (wr_data.size() !== NW) begin
            errs++;
            $display("FAIL b2b_second_count: got %0d want %0d", wr_data.size(), NW);
        end
        for (int i = 0; i < wr_data.size() && i < NW; i++) begin
            checks++;
            if (wr_data[i] !== exp_word(i, 0)) begin
                errs++;
                $display("FAIL b2b_word[%0d]: got %h want %h", i, wr_data[i], exp_word(i, 0));
            end
        end
    endtask

    task automatic test_relu;
        logic [31:0] neg_exp;
`ifdef PAD_WRITER_RELU_EN
        neg_exp = 32'h0;
`else
        neg_exp = 32'hBF800000;
`endif
        drive_frame(1, -1, 0, -1, 0, -1, 1'b0);
        checks++;
        if (wr_data.size() !== NW) begin
            errs++;
            $display("FAIL relu_count: got %0d want %0d", wr_data.size(), NW);
        end else begin
            checks++;
            if (wr_data[PW + 1] !== 32'h3F800000) begin
                errs++;
                $display("FAIL relu_pos: got %h want 3f800000", wr_data[PW + 1]);
            end
            checks++;
            if (wr_data[PW + 2] !== neg_exp) begin
                errs++;
                $display("FAIL relu_neg: got %h want %h", wr_data[PW + 2], neg_exp);
            end
        end
        for (int i = 0; i < wr_data.size() && i < NW; i++) begin
            checks++;
            if (wr_data[i] !== exp_word(i, 1)) begin
                errs++;
                $display("FAIL relu_word[%0d]: got %h want %h", i, wr_data[i], exp_word(i, 1));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        data_in   = '0;
        valid_in  = 1'b0;
        fifo_full = 1'b0;
        test_reset();
        test_basic_frame();
        test_fifo_stall();
        test_valid_gap();
        test_reset_midframe();
        test_back_to_back();
        test_relu();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
